line_sensor_filter: RTL and testbench

Conditions the four raw infrared line-tracking sensor inputs before they drive the direction-control stage. Each input is synchronised and debounced. The block presents a clean `path_sig[3:0]` to the direction controller in place of the raw pad signals. It also produces a change pulse, a line-lost flag after a sustained all-off period, and a last-seen-side memory for recovery steering.

---
 rtl/smartcar_pkg.sv | 20 ++
 rtl/sensor_debounce.sv | 61 ++++++
 rtl/line_sensor_filter.sv | 88 ++++++++
 tb/tb_line_sensor_filter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/smartcar_pkg.sv
// Shared constants for the smart-car sensor front end: sensor count, clock-derived
// filter timings and the last-seen-side encodings used for recovery steering.
package smartcar_pkg;

    localparam int N_SENS_DEFAULT = 4;
    localparam int CLK_HZ_DEFAULT = 50_000_000;

    // 1 ms debounce window and 0.5 s line-lost window at the default clock
    localparam int STABLE_CYCLES_DEFAULT = CLK_HZ_DEFAULT / 1000;
    localparam int LOST_CYCLES_DEFAULT   = CLK_HZ_DEFAULT / 2;
    localparam int CNT_W_DEFAULT         = 25;

    typedef enum logic [1:0] {
        SIDE_NONE   = 2'b00,
        SIDE_LEFT   = 2'b01,
        SIDE_RIGHT  = 2'b10,
        SIDE_CENTRE = 2'b11
    } side_e;

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit conditioner: two-flop synchroniser followed by a run-length debounce
// that flips the filtered level only after STABLE_CYCLES consecutive disagreements.
module sensor_debounce #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic sens_raw,
    output logic filt,
    output logic filt_next,
    output logic toggle
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             filt_r;
    logic             toggle_r;
    logic             flip_s;

    // Disagreement counter: any agreement restarts the window
    always_comb begin
        cnt_next_s = '0;
        flip_s     = 1'b0;
        if (sync2_r == filt_r) begin
            cnt_next_s = '0;
        end else if (cnt_r == STABLE_MAX) begin
            flip_s     = 1'b1;
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Synchroniser, counter, filtered level and toggle strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            cnt_r    <= '0;
            filt_r   <= 1'b0;
            toggle_r <= 1'b0;
        end else begin
            sync1_r  <= sens_raw;
            sync2_r  <= sync1_r;
            cnt_r    <= cnt_next_s;
            filt_r   <= filt_r ^ flip_s;
            toggle_r <= flip_s;
        end
    end

    assign filt      = filt_r;
    assign filt_next = filt_r ^ flip_s;
    assign toggle    = toggle_r;

endmodule

// File: rtl/line_sensor_filter.sv
// Conditions the raw line-tracking sensors into a debounced path vector, plus a
// change pulse, a sustained line-lost flag and the last side the line was seen on.
module line_sensor_filter
    import smartcar_pkg::*;
#(
    parameter int N_SENS        = N_SENS_DEFAULT,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int LOST_CYCLES   = LOST_CYCLES_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SENS-1:0] sens_raw,
    output logic [N_SENS-1:0] path_sig,
    output logic              path_chg,
    output logic              line_lost,
    output logic [1:0]        last_side
);

    localparam int               HALF     = N_SENS / 2;
    localparam logic [CNT_W-1:0] LOST_MAX = CNT_W'(LOST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_SENS-1:0] path_sig_s;
    logic [N_SENS-1:0] path_next_s;
    logic [N_SENS-1:0] toggle_s;
    logic [CNT_W-1:0]  lost_cnt_r;
    logic [CNT_W-1:0]  lost_cnt_next_s;
    logic              line_lost_r;
    logic              line_lost_next_s;
    side_e             last_side_r;
    side_e             side_next_s;

    for (genvar i = 0; i < N_SENS; i++) begin : g_bit
        sensor_debounce #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .sens_raw (sens_raw[i]),
            .filt     (path_sig_s[i]),
            .filt_next(path_next_s[i]),
            .toggle   (toggle_s[i])
        );
    end

    // Lost timer counts only across edges where the vector stays all-zero, so the
    // first all-zero cycle always carries count 0 whether it follows reset or a line
    always_comb begin
        lost_cnt_next_s  = '0;
        line_lost_next_s = 1'b0;
        side_next_s      = last_side_r;
        if ((path_next_s != '0) || (path_sig_s != '0)) begin
            lost_cnt_next_s = '0;
        end else if (lost_cnt_r == LOST_MAX) begin
            lost_cnt_next_s = LOST_MAX;
        end else begin
            lost_cnt_next_s = lost_cnt_r + CNT_ONE;
        end
        line_lost_next_s = (path_next_s == '0) && (lost_cnt_next_s == LOST_MAX);
        case ({|path_next_s[N_SENS-1:HALF], |path_next_s[HALF-1:0]})
            2'b10:   side_next_s = SIDE_LEFT;
            2'b01:   side_next_s = SIDE_RIGHT;
            2'b11:   side_next_s = SIDE_CENTRE;
            default: side_next_s = last_side_r;
        endcase
    end

    // Lost timer, lost flag and last-seen side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_cnt_r  <= '0;
            line_lost_r <= 1'b0;
            last_side_r <= SIDE_NONE;
        end else begin
            lost_cnt_r  <= lost_cnt_next_s;
            line_lost_r <= line_lost_next_s;
            last_side_r <= side_next_s;
        end
    end

    assign path_sig  = path_sig_s;
    assign path_chg  = |toggle_s;
    assign line_lost = line_lost_r;
    assign last_side = last_side_r;

endmodule

// File: tb/tb_line_sensor_filter.sv
// Randomised and directed checks of line_sensor_filter against a cycle-level
// behavioural model of the sensor filtering rules (STABLE_CYCLES=4, LOST_CYCLES=10).
module tb_line_sensor_filter;

    localparam int STABLE = 4;
    localparam int LOST   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sens_raw = 4'b0000;
    logic [3:0] path_sig;
    logic       path_chg;
    logic       line_lost;
    logic [1:0] last_side;

    int total = 0;
    int bad   = 0;

    // model state
    logic [3:0] m_s1, m_s2, m_filt;
    int         m_run [4];
    int         m_zero;
    logic       m_chg, m_lost;
    logic [1:0] m_side;

    line_sensor_filter #(
        .N_SENS(4), .STABLE_CYCLES(STABLE), .LOST_CYCLES(LOST), .CNT_W(25)
    ) dut (
        .clk(clk), .rst(rst), .sens_raw(sens_raw),
        .path_sig(path_sig), .path_chg(path_chg),
        .line_lost(line_lost), .last_side(last_side)
    );

    always #5 clk = ~clk;

    // Advance the reference by one rising edge using the inputs as they stand
    task automatic model_step();
        logic [3:0] nf;
        if (rst) begin
            m_s1 = 4'b0; m_s2 = 4'b0; m_filt = 4'b0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_zero = 1; m_chg = 1'b0; m_lost = 1'b0; m_side = 2'b00;
        end else begin
            nf = m_filt;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_filt[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= STABLE) begin
                        nf[i] = ~nf[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_chg = (nf != m_filt);
            if (nf == 4'b0) m_zero = (m_filt == 4'b0) ? ((m_zero < LOST) ? m_zero + 1 : LOST) : 1;
            else m_zero = 0;
            m_lost = (nf == 4'b0) && (m_zero >= LOST);
            if (nf[3:2] != 2'b0 && nf[1:0] != 2'b0) m_side = 2'b11;
            else if (nf[3:2] != 2'b0) m_side = 2'b01;
            else if (nf[1:0] != 2'b0) m_side = 2'b10;
            m_filt = nf; m_s2 = m_s1; m_s1 = sens_raw;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_zero();
        sens_raw = 4'b0000;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; sens_raw = 4'b0000;
        tick();
        for (int c = 1; c <= 13; c++) begin
            if (c == 2) rst = 1'b0;
            if (c > 1) tick();
            total++;
            if ({path_sig, path_chg, line_lost, last_side} !== {m_filt, m_chg, m_lost, m_side}) begin
                bad++;
                $display("FAIL reset_model cyc=%0d got=%b exp=%b", c,
                         {path_sig, path_chg, line_lost, last_side}, {m_filt, m_chg, m_lost, m_side});
            end
            total++;
            if ({path_sig, path_chg, last_side, line_lost} !== {4'b0, 1'b0, 2'b00, (c >= 10)}) begin
                bad++;
                $display("FAIL reset_const cyc=%0d got=%b exp=%b", c,
                         {path_sig, path_chg, last_side, line_lost}, {4'b0, 1'b0, 2'b00, (c >= 10)});
            end
        end
    endtask

    task automatic test_step();
        int n = 0;
        sens_raw = 4'b0110;
        while (path_sig !== 4'b0110 && n < 20) begin
            tick(); n++;
        end
        total++;
        if (n !== 6) begin bad++; $display("FAIL step_latency got=%0d exp=6", n); end
        total++;
        if ({path_chg, last_side, line_lost} !== {1'b1, 2'b11, 1'b0}) begin
            bad++; $display("FAIL step_flags got=%b exp=%b", {path_chg, last_side, line_lost}, 4'b1110);
        end
        tick();
        total++;
        if ({path_sig, path_chg} !== {4'b0110, 1'b0}) begin
            bad++; $display("FAIL step_after got=%b exp=%b", {path_sig, path_chg}, 5'b01100);
        end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        sens_raw = 4'b0100;
        for (int k = 0; k < 3; k++) tick();
        sens_raw = 4'b0110;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if ({path_sig, path_chg} !== {4'b0110, 1'b0}) begin
                bad++; $display("FAIL glitch_short k=%0d got=%b exp=%b", k, {path_sig, path_chg}, 5'b01100);
            end
        end
        sens_raw = 4'b0100;
        for (int k = 0; k < 4; k++) tick();
        sens_raw = 4'b0110;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (path_sig === 4'b0100) seen = 1'b1;
            total++;
            if ({path_sig, path_chg, line_lost, last_side} !== {m_filt, m_chg, m_lost, m_side}) begin
                bad++; $display("FAIL glitch_model k=%0d got=%b exp=%b", k,
                                {path_sig, path_chg, line_lost, last_side}, {m_filt, m_chg, m_lost, m_side});
            end
        end
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL glitch_long got=%b exp=1", seen); end
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_left_lost();
        int n = 0;
        settle_zero();
        sens_raw = 4'b1100;
        for (int k = 0; k < 8; k++) tick();
        total++;
        if ({path_sig, last_side} !== {4'b1100, 2'b01}) begin
            bad++; $display("FAIL left_side got=%b exp=%b", {path_sig, last_side}, 6'b110001);
        end
        sens_raw = 4'b0000;
        while (path_sig !== 4'b0000 && n < 20) begin tick(); n++; end
        total++;
        if (n !== 6) begin bad++; $display("FAIL left_clear got=%0d exp=6", n); end
        for (int z = 1; z <= 12; z++) begin
            if (z > 1) tick();
            total++;
            if ({line_lost, last_side} !== {(z >= 10), 2'b01}) begin
                bad++; $display("FAIL left_lost z=%0d got=%b exp=%b", z, {line_lost, last_side}, {(z >= 10), 2'b01});
            end
        end
    endtask

    task automatic test_simul();
        int n = 0;
        int pulses = 0;
        settle_zero();
        sens_raw = 4'b0011;
        while (path_sig === 4'b0000 && n < 20) begin tick(); n++; end
        total++;
        if ({path_sig, path_chg, last_side} !== {4'b0011, 1'b1, 2'b10}) begin
            bad++; $display("FAIL simul_update got=%b exp=%b", {path_sig, path_chg, last_side}, 7'b0011110);
        end
        pulses = 1;
        for (int k = 0; k < 6; k++) begin tick(); if (path_chg) pulses++; end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL simul_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        settle_zero();
        sens_raw = 4'b0001;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({path_sig, path_chg, line_lost, last_side} !== 8'b0) begin
            bad++; $display("FAIL midrst_outputs got=%b exp=%b", {path_sig, path_chg, line_lost, last_side}, 8'b0);
        end
        while (path_sig !== 4'b0001 && n < 20) begin tick(); n++; end
        total++;
        if (n !== 6) begin bad++; $display("FAIL midrst_latency got=%0d exp=6", n); end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                sens_raw = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 8);
            end
            hold--;
            rst = ($urandom_range(0, 199) == 0);
            tick();
            total++;
            if ({path_sig, path_chg, line_lost, last_side} !== {m_filt, m_chg, m_lost, m_side}) begin
                bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c,
                                {path_sig, path_chg, line_lost, last_side}, {m_filt, m_chg, m_lost, m_side});
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_left_lost();
        test_simul();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
